// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state encoding and the EXE operand forward-select codes.
package pipeline_stall_ctrl_pkg;

    typedef logic [0:0] ctrl_state_t;

    localparam ctrl_state_t RUN      = 1'b0;
    localparam ctrl_state_t MEM_WAIT = 1'b1;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_pick(input logic v,
                                            input logic mem_hit,
                                            input logic wb_hit);
        if (!v)
            return FWD_REG;
        if (mem_hit)
            return FWD_MEM;
        if (wb_hit)
            return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_stall_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Used for both the SRAM wait timer and the stall statistics counter.
module pipeline_stall_ctrl_stall_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != MAX))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazards, SRAM freeze, branch flush.
// Define FORWARDING_EN to restrict hazards to load-use and drive the EXE forward muxes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | pipeline advancing; no outstanding SRAM wait
// MEM_WAIT | MEM access pending; whole pipe frozen until sram_ready
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic             mem_access,
    input  logic             sram_ready,
    input  logic             branch_taken,
    input  logic             perf_clr,
    output logic             hazard,
    output logic             freeze_if,
    output logic             freeze_pipe,
    output logic             flush,
    output logic [1:0]       fwd_sel_src1,
    output logic [1:0]       fwd_sel_src2,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout_err
);

    localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    logic              mem_stall;
    logic              raw;
    logic              hazard_int;
    logic              flush_int;
    logic              in_wait;
    logic              err_set;
    logic [WAIT_W-1:0] wait_cnt;

    // Gated with RST so every combinational output is low while in reset.
    assign mem_stall  = RST && mem_access && !sram_ready;
    assign hazard_int = RST && raw && !mem_stall && !branch_taken;
    assign flush_int  = RST && branch_taken && !mem_stall;

    assign freeze_pipe = mem_stall;
    assign hazard      = hazard_int;
    assign freeze_if   = mem_stall || hazard_int;
    assign flush       = flush_int;

`ifdef FORWARDING_EN
    logic [3:0] exe_src1;
    logic [3:0] exe_src2;
    logic       exe_src_v;

    assign raw = id_valid && exe_mem_r_en && exe_wb_en &&
                 ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exe_src1  <= 4'd0;
            exe_src2  <= 4'd0;
            exe_src_v <= 1'b0;
        end else if (!mem_stall) begin
            exe_src1  <= id_src1;
            exe_src2  <= id_src2;
            exe_src_v <= id_valid && !hazard_int && !flush_int;
        end
    end

    assign fwd_sel_src1 = fwd_pick(exe_src_v,
                                   mem_wb_en && (mem_dest == exe_src1),
                                   wb_wb_en && (wb_dest == exe_src1));
    assign fwd_sel_src2 = fwd_pick(exe_src_v,
                                   mem_wb_en && (mem_dest == exe_src2),
                                   wb_wb_en && (wb_dest == exe_src2));
`else
    logic unused_fwd_inputs;

    assign raw = id_valid &&
                 ((exe_wb_en && (exe_dest == id_src1)) ||
                  (mem_wb_en && (mem_dest == id_src1)) ||
                  (id_two_src && ((exe_wb_en && (exe_dest == id_src2)) ||
                                  (mem_wb_en && (mem_dest == id_src2)))));

    assign unused_fwd_inputs = ^{wb_dest, wb_wb_en, exe_mem_r_en};
    assign fwd_sel_src1      = FWD_REG;
    assign fwd_sel_src2      = FWD_REG;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (sram_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    assign in_wait = (state_q == MEM_WAIT);

    // Held at zero in RUN, so it always starts from zero on entering MEM_WAIT.
    pipeline_stall_ctrl_stall_counter #(
        .W   (WAIT_W),
        .MAX (WAIT_MAX)
    ) u_wait_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (!in_wait),
        .inc   (in_wait),
        .count (wait_cnt)
    );

    assign err_set = in_wait && (wait_cnt >= WAIT_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            mem_timeout_err <= 1'b0;
        else if (perf_clr)
            mem_timeout_err <= 1'b0;
        else if (err_set)
            mem_timeout_err <= 1'b1;
    end

    pipeline_stall_ctrl_stall_counter #(
        .W   (CNT_W),
        .MAX (STALL_MAX)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (perf_clr),
        .inc   (mem_stall || hazard_int),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl against a cycle-level behavioural model.
// Covers both builds; forwarding checks are compiled in only with FORWARDING_EN.
module tb_pipeline_stall_ctrl;
    import pipeline_stall_ctrl_pkg::*;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic             wb_wb_en, mem_access, sram_ready, branch_taken, perf_clr;
    logic [3:0]       id_src1, id_src2, exe_dest, mem_dest, wb_dest;
    logic             hazard, freeze_if, freeze_pipe, flush, mem_timeout_err;
    logic [1:0]       fwd_sel_src1, fwd_sel_src2;
    logic [CNT_W-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    // model state
    bit m_wait, m_err, m_v;
    int m_wcnt, m_cnt, m_src1, m_src2;
    // model expectations for the current cycle
    bit e_hz, e_fp, e_fl, e_fi;
    int e_f1, e_f2;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .mem_access(mem_access), .sram_ready(sram_ready), .branch_taken(branch_taken),
        .perf_clr(perf_clr), .hazard(hazard), .freeze_if(freeze_if), .freeze_pipe(freeze_pipe),
        .flush(flush), .fwd_sel_src1(fwd_sel_src1), .fwd_sel_src2(fwd_sel_src2),
        .stall_count(stall_count), .mem_timeout_err(mem_timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        id_valid = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        wb_wb_en = 0; mem_access = 0; sram_ready = 0; branch_taken = 0; perf_clr = 0;
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0; wb_dest = 0;
    endtask

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_v = 0; m_wcnt = 0; m_cnt = 0; m_src1 = 0; m_src2 = 0;
    endtask

    function automatic int fwd_of(int src);
        if (!m_v) return 0;
        if (mem_wb_en && mem_dest == src) return 1;
        if (wb_wb_en && wb_dest == src) return 2;
        return 0;
    endfunction

    task automatic model_comb();
        bit raw;
        if (FEAT)
            raw = id_valid && exe_mem_r_en && exe_wb_en &&
                  (exe_dest == id_src1 || (id_two_src && exe_dest == id_src2));
        else
            raw = id_valid && ((exe_wb_en && exe_dest == id_src1) || (mem_wb_en && mem_dest == id_src1) ||
                  (id_two_src && ((exe_wb_en && exe_dest == id_src2) || (mem_wb_en && mem_dest == id_src2))));
        e_fp = RST && mem_access && !sram_ready;
        e_hz = RST && raw && !e_fp && !branch_taken;
        e_fl = RST && branch_taken && !e_fp;
        e_fi = e_fp || e_hz;
        e_f1 = FEAT ? fwd_of(m_src1) : 0;
        e_f2 = FEAT ? fwd_of(m_src2) : 0;
    endtask

    task automatic model_tick();
        if (perf_clr) begin
            m_cnt = 0;
            m_err = 0;
        end else if (e_fi) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
        if (m_wait) begin
            m_wcnt++;
            if (m_wcnt >= TIMEOUT && !perf_clr) m_err = 1;
        end
        if (m_wait && sram_ready) m_wait = 0;
        else if (!m_wait && e_fp) begin m_wait = 1; m_wcnt = 0; end
        if (!e_fp) begin
            m_src1 = id_src1; m_src2 = id_src2; m_v = id_valid && !e_hz && !e_fl;
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        model_comb();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_tick();
        #1;
    endtask

    task automatic clear_perf();
        perf_clr = 1;
        settle();
        tick();
        perf_clr = 0;
    endtask

    task automatic test_reset();
        idle();
        exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 3; id_valid = 1;
        mem_access = 1; branch_taken = 1;
        repeat (2) @(negedge CLK);
        total++;
        if ({hazard, freeze_if, freeze_pipe, flush, fwd_sel_src1, fwd_sel_src2} !== 8'h00) begin
            bad++; $display("FAIL reset_outs: got %b want 00000000",
                {hazard, freeze_if, freeze_pipe, flush, fwd_sel_src1, fwd_sel_src2});
        end
        total++;
        if (stall_count !== '0 || mem_timeout_err !== 1'b0) begin
            bad++; $display("FAIL reset_regs: got cnt=%0d err=%b want 0 0", stall_count, mem_timeout_err);
        end
        idle();
        model_reset();
        @(posedge CLK); #1 RST = 1;
    endtask

    task automatic test_raw_exe();
        idle();
        clear_perf();
        exe_dest = 3; exe_wb_en = 1; id_src1 = 3; id_valid = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (hazard !== e_hz || freeze_if !== e_fi || stall_count !== m_cnt[CNT_W-1:0]) begin
                bad++; $display("FAIL raw_exe[%0d]: got hz=%b fi=%b cnt=%0d want %b %b %0d",
                    i, hazard, freeze_if, stall_count, e_hz, e_fi, m_cnt);
            end
            if (!FEAT) begin
                total++;
                if (hazard !== 1'b1) begin
                    bad++; $display("FAIL raw_exe_const[%0d]: got %b want 1", i, hazard);
                end
            end
            tick();
        end
        settle();
        total++;
        if (stall_count !== m_cnt[CNT_W-1:0]) begin
            bad++; $display("FAIL raw_exe_cnt: got %0d want %0d", stall_count, m_cnt);
        end
        id_valid = 0;
        settle();
        total++;
        if (hazard !== 1'b0) begin
            bad++; $display("FAIL raw_bubble: got %b want 0", hazard);
        end
        tick();
    endtask

    task automatic test_store_src2();
        idle();
        id_valid = 1; id_two_src = 1; id_src1 = 0; id_src2 = 5; mem_dest = 5; mem_wb_en = 1;
        settle();
        total++;
        if (hazard !== e_hz || hazard !== !FEAT) begin
            bad++; $display("FAIL store_src2: got %b want %b", hazard, e_hz);
        end
        tick();
        id_two_src = 0;
        settle();
        total++;
        if (hazard !== 1'b0) begin
            bad++; $display("FAIL store_one_src: got %b want 0", hazard);
        end
        tick();
    endtask

    task automatic test_mem_wait(input int k);
        idle();
        clear_perf();
        mem_access = 1;
        for (int i = 0; i < k; i++) begin
            settle();
            total++;
            if (freeze_pipe !== 1'b1 || freeze_if !== 1'b1) begin
                bad++; $display("FAIL mem_wait_freeze[%0d]: got fp=%b fi=%b want 1 1", i, freeze_pipe, freeze_if);
            end
            tick();
        end
        sram_ready = 1;
        settle();
        total++;
        if (freeze_pipe !== 1'b0) begin
            bad++; $display("FAIL mem_wait_release: got %b want 0", freeze_pipe);
        end
        tick();
        idle();
        repeat (2) begin settle(); tick(); end
        settle();
        total++;
        if (stall_count !== k || stall_count !== m_cnt[CNT_W-1:0] ||
            mem_timeout_err !== m_err || mem_timeout_err !== (k >= 4)) begin
            bad++; $display("FAIL mem_wait_%0d: got cnt=%0d err=%b want %0d %b", k, stall_count,
                mem_timeout_err, m_cnt, m_err);
        end
        tick();
    endtask

    task automatic test_timeout_clear();
        clear_perf();
        settle();
        total++;
        if (mem_timeout_err !== 1'b0 || stall_count !== '0) begin
            bad++; $display("FAIL timeout_clear: got err=%b cnt=%0d want 0 0", mem_timeout_err, stall_count);
        end
        tick();
    endtask

    task automatic test_branch_in_wait();
        idle();
        mem_access = 1; branch_taken = 1;
        id_valid = 1; id_src1 = 6; exe_dest = 6; exe_wb_en = 1; exe_mem_r_en = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (flush !== 1'b0 || hazard !== 1'b0 || freeze_pipe !== 1'b1) begin
                bad++; $display("FAIL branch_deferred[%0d]: got fl=%b hz=%b fp=%b want 0 0 1", i, flush, hazard, freeze_pipe);
            end
            tick();
        end
        sram_ready = 1;
        settle();
        total++;
        if (flush !== 1'b1 || hazard !== 1'b0) begin
            bad++; $display("FAIL branch_fire: got fl=%b hz=%b want 1 0", flush, hazard);
        end
        tick();
        idle();
        settle();
        total++;
        if (flush !== 1'b0) begin
            bad++; $display("FAIL branch_one_cycle: got %b want 0", flush);
        end
        tick();
    endtask

    task automatic test_saturation();
        idle();
        clear_perf();
        exe_dest = 9; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 9; id_valid = 1;
        repeat (CNT_MAX + 8) begin settle(); tick(); end
        settle();
        total++;
        if (stall_count !== CNT_MAX[CNT_W-1:0] || m_cnt != CNT_MAX) begin
            bad++; $display("FAIL saturate: got %0d want %0d", stall_count, CNT_MAX);
        end
        tick();
        idle();
    endtask

`ifdef FORWARDING_EN
    task automatic test_forwarding();
        idle();
        id_valid = 1; id_src1 = 2; exe_dest = 2; exe_wb_en = 1;
        settle();
        total++;
        if (hazard !== 1'b0) begin
            bad++; $display("FAIL fwd_alu_hazard: got %b want 0", hazard);
        end
        tick();
        idle();
        mem_dest = 2; mem_wb_en = 1; exe_dest = 7; exe_wb_en = 1;
        settle();
        total++;
        if (fwd_sel_src1 !== FWD_MEM || fwd_sel_src1 !== e_f1[1:0]) begin
            bad++; $display("FAIL fwd_alu_mem: got %b want %b", fwd_sel_src1, FWD_MEM);
        end
        tick();
        idle();
        exe_dest = 4; exe_wb_en = 1; exe_mem_r_en = 1; id_valid = 1; id_src1 = 4;
        settle();
        total++;
        if (hazard !== 1'b1) begin
            bad++; $display("FAIL load_use_hazard: got %b want 1", hazard);
        end
        tick();
        exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 4; mem_wb_en = 1;
        settle();
        total++;
        if (hazard !== 1'b0 || fwd_sel_src1 !== FWD_REG) begin
            bad++; $display("FAIL load_use_bubble: got hz=%b fwd=%b want 0 00", hazard, fwd_sel_src1);
        end
        tick();
        idle();
        wb_dest = 4; wb_wb_en = 1;
        settle();
        total++;
        if (fwd_sel_src1 !== FWD_WB || fwd_sel_src1 !== e_f1[1:0]) begin
            bad++; $display("FAIL load_use_fwd: got %b want %b", fwd_sel_src1, FWD_WB);
        end
        tick();
        idle();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = $urandom_range(0, 3) != 0;
            id_two_src = $urandom_range(0, 1);
            id_src1 = 4'($urandom_range(0, 7)); id_src2 = 4'($urandom_range(0, 7));
            exe_dest = 4'($urandom_range(0, 7)); exe_wb_en = $urandom_range(0, 1);
            exe_mem_r_en = $urandom_range(0, 1);
            mem_dest = 4'($urandom_range(0, 7)); mem_wb_en = $urandom_range(0, 1);
            wb_dest = 4'($urandom_range(0, 7)); wb_wb_en = $urandom_range(0, 1);
            mem_access = $urandom_range(0, 2) == 0; sram_ready = $urandom_range(0, 2) == 0;
            branch_taken = $urandom_range(0, 4) == 0; perf_clr = $urandom_range(0, 40) == 0;
            settle();
            total++;
            if ({hazard, freeze_if, freeze_pipe, flush, fwd_sel_src1, fwd_sel_src2, mem_timeout_err} !==
                {e_hz, e_fi, e_fp, e_fl, e_f1[1:0], e_f2[1:0], m_err} || stall_count !== m_cnt[CNT_W-1:0]) begin
                bad++; $display("FAIL random[%0d]: got hz=%b fi=%b fp=%b fl=%b f1=%0d f2=%0d err=%b cnt=%0d want %b %b %b %b %0d %0d %b %0d",
                    i, hazard, freeze_if, freeze_pipe, flush, fwd_sel_src1, fwd_sel_src2, mem_timeout_err,
                    stall_count, e_hz, e_fi, e_fp, e_fl, e_f1, e_f2, m_err, m_cnt);
            end
            total++;
            if ((flush && hazard) !== 1'b0) begin
                bad++; $display("FAIL random_excl[%0d]: got flush&hazard=%b want 0", i, flush && hazard);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_wait();
        idle();
        clear_perf();
        mem_access = 1;
        repeat (7) begin settle(); tick(); end
        settle();
        total++;
        if (stall_count !== 5'd7 || m_cnt != 7) begin
            bad++; $display("FAIL pre_reset_cnt: got %0d want 7", stall_count);
        end
        RST = 0;
        #1;
        total++;
        if ({hazard, freeze_if, freeze_pipe, flush, fwd_sel_src1, fwd_sel_src2, mem_timeout_err} !== 9'h0 ||
            stall_count !== '0) begin
            bad++; $display("FAIL async_reset: got fp=%b fi=%b err=%b cnt=%0d want all 0",
                freeze_pipe, freeze_if, mem_timeout_err, stall_count);
        end
        model_reset();
        idle();
        @(posedge CLK); #1 RST = 1;
        repeat (5) begin settle(); tick(); end
        settle();
        total++;
        if (mem_timeout_err !== 1'b0 || freeze_pipe !== 1'b0 || stall_count !== '0) begin
            bad++; $display("FAIL post_reset_run: got err=%b fp=%b cnt=%0d want 0 0 0",
                mem_timeout_err, freeze_pipe, stall_count);
        end
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_raw_exe();
        test_store_src2();
        test_mem_wait(2);
        test_mem_wait(4);
        test_timeout_clear();
        test_branch_in_wait();
        test_saturation();
`ifdef FORWARDING_EN
        test_forwarding();
`endif
        test_random();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
